pwm_duty_decoder: RTL

Receive-side counterpart of the motor PWM generator. It samples an external PWM line, measures high time and period in clk cycles, and inverts the generator's duty mapping to recover the signed 12-bit duty_ratio. It sits between a PWM input pin (feedback, loopback test, or upstream controller) and the motor-control logic.

---
 rtl/pwm_pkg.sv | 40 ++++
 rtl/pwm_edge_sync.sv | 65 ++++++
 rtl/pwm_duty_decoder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Constants and types shared by the PWM generator and the PWM duty decoder, so the
// high-time mapping used on both sides cannot drift apart.
package pwm_pkg;

  localparam int unsigned DUTY_W     = 12;
  localparam int unsigned CNT_W      = 12;
  localparam int unsigned GLITCH_LEN = 4;

  localparam logic [CNT_W-1:0] PERIOD_NOM = 12'd2000;
  localparam logic [CNT_W-1:0] POS_OFFSET = 12'd1330;
  localparam logic [CNT_W-1:0] NEG_OFFSET = 12'd780;

  localparam logic signed [DUTY_W:0] DUTY_MAX = 13'sd2047;
  localparam logic signed [DUTY_W:0] DUTY_MIN = -13'sd2048;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } pwm_state_e;

  // Inverse of the generator mapping: positive duty above POS_OFFSET, negative below
  // NEG_OFFSET, deadband in between.
  function automatic logic signed [DUTY_W-1:0] duty_from_high(input logic [CNT_W-1:0] hcnt);
    logic signed [DUTY_W:0] wide;
    wide = '0;
    if (hcnt > POS_OFFSET) begin
      wide = $signed({1'b0, hcnt}) - $signed({1'b0, POS_OFFSET});
    end else if (hcnt < NEG_OFFSET) begin
      wide = $signed({1'b0, hcnt}) - $signed({1'b0, NEG_OFFSET});
    end
    if (wide > DUTY_MAX) begin
      wide = DUTY_MAX;
    end else if (wide < DUTY_MIN) begin
      wide = DUTY_MIN;
    end
    return wide[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the asynchronous PWM line and produces single-cycle edge strobes.
// Optional 4-sample stability filter when PWM_DECODE_GLITCH_FILTER_EN is defined.
module pwm_edge_sync
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic rise_stb,
  output logic fall_stb
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_DECODE_GLITCH_FILTER_EN
  logic       filt_q;
  logic [1:0] stable_q;

  // Level follows the synchronized line only after GLITCH_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q   <= 1'b0;
      stable_q <= '0;
    end else if (sync2_q != filt_q) begin
      if (stable_q == 2'(GLITCH_LEN - 1)) begin
        filt_q   <= sync2_q;
        stable_q <= '0;
      end else begin
        stable_q <= stable_q + 2'd1;
      end
    end else begin
      stable_q <= '0;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise_stb = level & ~level_q;
  assign fall_stb = ~level & level_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures high time and period of an incoming PWM line and recovers the signed duty.
// Build option PWM_DECODE_GLITCH_FILTER_EN enables the input stability filter.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD_TOL = 16,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pwm_in,
  output logic signed [DUTY_W-1:0] duty_ratio,
  output logic        [CNT_W-1:0]  high_cnt,
  output logic        [CNT_W-1:0]  period_cnt,
  output logic                     valid,
  output logic                     period_err,
  output logic                     timeout
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TolCnt     = CNT_W'(PERIOD_TOL);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  logic rise_stb;
  logic fall_stb;

  pwm_edge_sync u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .pwm_in   (pwm_in),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  pwm_state_e state_q, state_d;
  logic        [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic        [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic signed [DUTY_W-1:0] duty_q, duty_d;
  logic        [CNT_W-1:0]  high_q, high_d;
  logic        [CNT_W-1:0]  period_q, period_d;
  logic                     valid_q, valid_d;
  logic                     perr_q, perr_d;
  logic                     tmo_q, tmo_d;

  logic [CNT_W-1:0] pdev;
  logic             perr_now;

  assign pdev     = (pcnt_q >= PERIOD_NOM) ? (pcnt_q - PERIOD_NOM) : (PERIOD_NOM - pcnt_q);
  assign perr_now = (pdev > TolCnt);

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    pcnt_d   = pcnt_q;
    duty_d   = duty_q;
    high_d   = high_q;
    period_d = period_q;
    valid_d  = 1'b0;
    perr_d   = perr_q;
    tmo_d    = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (rise_stb) begin
          hcnt_d  = CntOne;
          pcnt_d  = CntOne;
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (pcnt_q == TimeoutCnt) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          duty_d  = '0;
          valid_d = 1'b1;
        end else if (fall_stb) begin
          pcnt_d  = pcnt_q + CntOne;
          state_d = LOW;
        end else begin
          hcnt_d = hcnt_q + CntOne;
          pcnt_d = pcnt_q + CntOne;
        end
      end

      LOW: begin
        // A closing edge on the same cycle the limit is reached still completes the frame.
        if (rise_stb) begin
          high_d   = hcnt_q;
          period_d = pcnt_q;
          perr_d   = perr_now;
          duty_d   = duty_from_high(hcnt_q);
          valid_d  = 1'b1;
          tmo_d    = 1'b0;
          hcnt_d   = CntOne;
          pcnt_d   = CntOne;
          state_d  = HIGH;
        end else if (pcnt_q == TimeoutCnt) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          duty_d  = '0;
          valid_d = 1'b1;
        end else begin
          pcnt_d = pcnt_q + CntOne;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      duty_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      pcnt_q   <= pcnt_d;
      duty_q   <= duty_d;
      high_q   <= high_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      tmo_q    <= tmo_d;
    end
  end

  assign duty_ratio = duty_q;
  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign valid      = valid_q;
  assign period_err = perr_q;
  assign timeout    = tmo_q;

endmodule
